// File: rtl/frame_tap_pkg.sv
// -----------------------------------------------------------------------------
// frame_tap_pkg
// Shared definitions for the frame-aligned tap selector:
//   - tap_state_e      : selector FSM states (PASS, FINISH, ALIGN)
//   - DefaultFrameLen  : elements per frame of a valid-only KxK convolution
//                        over a 320x240 image ((320-K+1) x (240-K+1))
//   - decode_request() : one-hot button vector -> requested tap index
// -----------------------------------------------------------------------------
package frame_tap_pkg;

  typedef enum logic [1:0] {
    PASS   = 2'd0,  // active tap streams to the output
    FINISH = 2'd1,  // switch pending, active tap completes its frame
    ALIGN  = 2'd2   // output idle, waiting for the pending tap's frame start
  } tap_state_e;

  localparam int unsigned ImageWidth      = 320;
  localparam int unsigned ImageHeight     = 240;
  localparam int unsigned KernelWidth     = 3;
  localparam int unsigned DefaultFrameLen =
      (ImageWidth - KernelWidth + 1) * (ImageHeight - KernelWidth + 1);

  // Upper bound on button vector width accepted by decode_request().
  localparam int unsigned MaxButtons = 31;

  // Exactly one button high selects that tap; none or several fall back to
  // the default tap.
  function automatic int unsigned decode_request(
    input logic [MaxButtons-1:0] buttons,
    input int unsigned           default_tap
  );
    int unsigned hits;
    int unsigned sel;
    hits = 0;
    sel  = default_tap;
    for (int unsigned b = 0; b < MaxButtons; b++) begin
      if (buttons[b]) begin
        hits = hits + 1;
        sel  = b;
      end
    end
    return (hits == 1) ? sel : default_tap;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Two-flop synchroniser for a vector of raw asynchronous buttons, followed
// (when FRAME_TAP_DEBOUNCE_EN is defined) by a vector-wide debounce: the
// output only takes the synchronised value after it has differed from the
// current output for DebounceCycles consecutive cycles. Without the macro the
// synchroniser output is used directly and no counter is built.
//
// Ports:
//   clk_i     in   clock
//   rst_ni    in   asynchronous active-low reset
//   button_i  in   [Width] raw buttons
//   button_o  out  [Width] synchronised (and debounced) buttons
// -----------------------------------------------------------------------------
module button_debounce #(
  parameter int unsigned Width          = 3,
  parameter int unsigned DebounceCycles = 250000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] button_i,
  output logic [Width-1:0] button_o
);

  logic [Width-1:0] sync1_q, sync1_d;
  logic [Width-1:0] sync2_q, sync2_d;

  assign sync1_d = button_i;
  assign sync2_d = sync1_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef FRAME_TAP_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DebounceCycles + 1);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] stable_q, stable_d;

  // Count cycles in which the synchronised level differs from the accepted
  // level; any return to the accepted level restarts the count. The update
  // lands DebounceCycles edges after the synchroniser shows the new level.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntW'(DebounceCycles - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign button_o = stable_q;
`else
  assign button_o = sync2_q;
`endif

endmodule

// File: rtl/frame_tap_select.sv
// -----------------------------------------------------------------------------
// frame_tap_select
// Frame-aligned N-way stream selector. Button requests are synchronised
// (optionally debounced, macro FRAME_TAP_DEBOUNCE_EN) and a change of source
// only takes effect once the outgoing tap has delivered its last beat and the
// incoming tap is at the start of a frame. last_o is generated from a per-tap
// element counter.
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. A source holds valid and data until it is accepted; the output
// likewise never withdraws valid_o without a transfer, except in the cycle
// the selector switches source, which always directly follows the
// transfer of the outgoing tap's last beat.
//
// Ports:
//   clk_i         in   clock
//   rst_ni        in   asynchronous active-low reset
//   button_i      in   [NumTaps-1] raw buttons, bit b requests tap b
//   valid_i       in   [NumTaps] per-tap valid
//   data_i        in   [NumTaps*DataWidth] per-tap element, tap t at slice t
//   ready_o       out  [NumTaps] per-tap ready
//   valid_o       out  output valid
//   data_o        out  [DataWidth] output element
//   last_o        out  final element of an output frame
//   ready_i       in   downstream ready
//   active_tap_o  out  [SelWidth] tap driving the output
//   switching_o   out  high whenever the FSM is not in PASS
// -----------------------------------------------------------------------------
module frame_tap_select
  import frame_tap_pkg::*;
#(
  parameter int unsigned NumTaps              = 4,
  parameter int unsigned DataWidth            = 1,
  parameter int unsigned TapFrameLen[NumTaps] = '{default: DefaultFrameLen},
  parameter int unsigned DefaultTap           = NumTaps - 1,
  parameter int unsigned DebounceCycles       = 250000,
  localparam int unsigned SelWidth            = $clog2(NumTaps)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumTaps-2:0]           button_i,
  input  logic [NumTaps-1:0]           valid_i,
  input  logic [NumTaps*DataWidth-1:0] data_i,
  output logic [NumTaps-1:0]           ready_o,
  output logic                         valid_o,
  output logic [DataWidth-1:0]         data_o,
  output logic                         last_o,
  input  logic                         ready_i,
  output logic [SelWidth-1:0]          active_tap_o,
  output logic                         switching_o
);

  function automatic int unsigned max_frame_len();
    int unsigned m;
    m = 1;
    for (int t = 0; t < NumTaps; t++) begin
      if (TapFrameLen[t] > m) m = TapFrameLen[t];
    end
    return m;
  endfunction

  localparam int unsigned MaxLen = max_frame_len();
  localparam int unsigned CntW   = (MaxLen > 1) ? $clog2(MaxLen) : 1;

  logic [NumTaps-2:0]   btn_db;
  logic [SelWidth-1:0]  req;

  tap_state_e           state_q, state_d;
  logic [SelWidth-1:0]  act_q, act_d;
  logic [SelWidth-1:0]  pend_q, pend_d;
  logic                 run_q, run_d;
  logic [CntW-1:0]      cnt_q [NumTaps];
  logic [CntW-1:0]      cnt_d [NumTaps];

  logic [DataWidth-1:0] tap_data [NumTaps];
  logic [NumTaps-1:0]   hs;         // beat transferred on tap t this cycle
  logic [NumTaps-1:0]   last_beat;  // tap t sits on its final frame element
  logic [NumTaps-1:0]   wraps;      // tap t's counter is 0 next cycle
  logic                 frame_done;

  button_debounce #(
    .Width          (NumTaps - 1),
    .DebounceCycles (DebounceCycles)
  ) u_button_debounce (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .button_i (button_i),
    .button_o (btn_db)
  );

  assign req = SelWidth'(decode_request(MaxButtons'(btn_db), DefaultTap));

  // Outputs stay quiet for the first cycle after reset release.
  assign run_d = 1'b1;

  always_comb begin
    ready_o = {NumTaps{run_q}};
    if (state_q != ALIGN) ready_o[act_q] = run_q & ready_i;
  end

  for (genvar t = 0; t < NumTaps; t++) begin : g_tap
    localparam logic [CntW-1:0] LastIdx = CntW'(TapFrameLen[t] - 1);

    assign tap_data[t]  = data_i[t*DataWidth +: DataWidth];
    assign hs[t]        = valid_i[t] & ready_o[t];
    assign last_beat[t] = (cnt_q[t] == LastIdx);
    assign cnt_d[t]     = !hs[t]       ? cnt_q[t] :
                          last_beat[t] ? '0       : cnt_q[t] + CntW'(1);
    assign wraps[t]     = hs[t] ? last_beat[t] : (cnt_q[t] == '0);
  end

  always_comb begin
    valid_o = run_q & (state_q != ALIGN) & valid_i[act_q];
    data_o  = valid_o ? tap_data[act_q] : '0;
    last_o  = valid_o & last_beat[act_q];
  end

  assign frame_done   = hs[act_q] & last_beat[act_q] & (state_q != ALIGN);
  assign active_tap_o = act_q;
  assign switching_o  = (state_q != PASS);

  // A switch is taken at the edge where the outgoing tap's last beat
  // transfers, provided the incoming tap's counter is 0 on the following
  // cycle (either it wraps on that same edge or it is idle at 0). The
  // incoming tap is never ready-stalled while pending, so waiting for its
  // wrap in ALIGN always terminates.
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    pend_d  = pend_q;
    unique case (state_q)
      PASS, FINISH: begin
        if (req == act_q) begin
          state_d = PASS;
        end else begin
          pend_d = req;
          if (frame_done) begin
            if (wraps[req]) begin
              act_d   = req;
              state_d = PASS;
            end else begin
              state_d = ALIGN;
            end
          end else begin
            state_d = FINISH;
          end
        end
      end
      ALIGN: begin
        pend_d = req;
        if (wraps[req]) begin
          act_d   = req;
          state_d = PASS;
        end
      end
      default: state_d = PASS;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PASS;
      act_q   <= SelWidth'(DefaultTap);
      pend_q  <= SelWidth'(DefaultTap);
      run_q   <= 1'b0;
      for (int t = 0; t < NumTaps; t++) cnt_q[t] <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      run_q   <= run_d;
      for (int t = 0; t < NumTaps; t++) cnt_q[t] <= cnt_d[t];
    end
  end

endmodule
